riscv_mdu: RTL

- Parametrised iterative multiply/divide unit implementing the full RV32M/RV64M funct3 set (MUL..REMU).
- Sits beside the ALU in the EX stage. The hazard unit stalls PC, IF/ID and ID/EX while `busy` is high.
- Uses a start/busy/done handshake and accepts a pipeline flush (branch redirect) that aborts an operation in flight.

---
 rtl/riscv_mdu_pkg.sv | 44 ++++
 rtl/riscv_mdu_div_step.sv | 25 ++
 rtl/riscv_mdu.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/riscv_mdu_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit:
// funct3 encodings, FSM state encoding and op-class decode helpers.
package riscv_mdu_pkg;

    localparam logic [2:0] MDU_OP_MUL    = 3'b000;
    localparam logic [2:0] MDU_OP_MULH   = 3'b001;
    localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
    localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
    localparam logic [2:0] MDU_OP_DIV    = 3'b100;
    localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
    localparam logic [2:0] MDU_OP_REM    = 3'b110;
    localparam logic [2:0] MDU_OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // Multiply ops other than MUL return the upper half of the product.
    function automatic logic op_is_mulh(input logic [2:0] op);
        return op[1:0] != 2'b00;
    endfunction

    // Signed rs1: MUL, MULH, MULHSU, DIV, REM.
    function automatic logic op_a_signed(input logic [2:0] op);
        return op[2] ? ~op[0] : (op[1:0] != 2'b11);
    endfunction

    // Signed rs2: MUL, MULH, DIV, REM.
    function automatic logic op_b_signed(input logic [2:0] op);
        return op[2] ? ~op[0] : ~op[1];
    endfunction

endpackage

// File: rtl/riscv_mdu_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor if it fits.
module mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // rem_i < divisor, so the shifted value fits in XLEN+1 bits and a clear
    // MSB of the trial difference means the subtraction did not borrow.
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {1'b0, divisor_i};
        q_o     = ~trial[XLEN];
        rem_o   = q_o ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/riscv_mdu.sv
// Iterative multiply/divide unit for the EX stage: one bit per cycle,
// sign fix-up in a final cycle, and single-cycle fast paths for corner cases.
module riscv_mdu
    import riscv_mdu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    mdu_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept;
    logic                a_neg, b_neg;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic                b_zero, ovf, fast;
    logic [XLEN-1:0]     fast_res;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, div_next, prod;
    logic [XLEN-1:0]     div_rem;
    logic                div_q;
    logic [XLEN-1:0]     mul_res, div_res, quo, rem;
    logic                neg;

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i     (acc_q[2*XLEN-1:XLEN]),
        .bit_i     (acc_q[XLEN-1]),
        .divisor_i (b_q),
        .rem_o     (div_rem),
        .q_o       (div_q)
    );

    always_comb begin
        accept   = start & ~busy_q & ~flush;
        a_neg    = op_a_signed(op) & a[XLEN-1];
        b_neg    = op_b_signed(op) & b[XLEN-1];
        abs_a    = a_neg ? -a : a;
        abs_b    = b_neg ? -b : b;
        b_zero   = (b == '0);
        ovf      = op_is_div(op) & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
        fast     = op_is_div(op) & (b_zero | ovf);
        if (b_zero) fast_res = op_is_rem(op) ? a : '1;
        else        fast_res = op_is_rem(op) ? '0 : a;

        // Multiply: acc = {partial product, remaining multiplier bits}.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        // Divide: acc = {partial remainder, dividend bits / quotient bits}.
        div_next = {div_rem, acc_q[XLEN-2:0], div_q};

        neg      = sa_q ^ sb_q;
        prod     = neg ? -acc_q : acc_q;
        mul_res  = op_is_mulh(op_q) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        quo      = acc_q[XLEN-1:0];
        rem      = acc_q[2*XLEN-1:XLEN];
        if (op_is_rem(op_q)) div_res = sa_q ? -rem : rem;
        else                 div_res = neg ? -quo : quo;

        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        b_d      = b_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        acc_d    = acc_q;
        result_d = result_q;

        unique case (state_q)
            MDU_IDLE, MDU_DONE: begin
                state_d = MDU_IDLE;
                if (accept) begin
                    op_d  = op;
                    b_d   = abs_b;
                    sa_d  = a_neg;
                    sb_d  = b_neg;
                    acc_d = {{XLEN{1'b0}}, abs_a};
                    cnt_d = CNT_W'(XLEN - 1);
                    if (fast) begin
                        state_d  = MDU_DONE;
                        result_d = fast_res;
                    end else begin
                        state_d  = MDU_CALC;
                    end
                end
            end
            MDU_CALC: begin
                acc_d = op_is_div(op_q) ? div_next : mul_next;
                if (cnt_q == '0) state_d = MDU_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            MDU_FIX: begin
                state_d  = MDU_DONE;
                result_d = op_is_div(op_q) ? div_res : mul_res;
            end
            default: state_d = MDU_IDLE;
        endcase

        if (flush) begin
            state_d  = MDU_IDLE;
            result_d = result_q;
        end

        busy_d = (state_d == MDU_CALC) | (state_d == MDU_FIX);
        done_d = (state_d == MDU_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            b_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            b_q      <= b_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
